facto_queue_core: RTL

Memory-mapped, parametrised factorial accelerator and successor to the single-operand factorial core on the same 64-bit slave bus. Operands go into an operand FIFO and are processed back-to-back by an iterative shift-add datapath. Each 2×DATA_W-bit result, with its overflow flag, goes into a result FIFO. The host pops results at its own pace, and an optional level interrupt flags pending results.

---
 rtl/facto_queue_core_if.sv | 26 ++
 rtl/facto_queue_core.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/facto_queue_core_if.sv
`default_nettype none
`timescale 1ns/1ps
// ------------------------------------------------------------------
// facto_queue_core_if: slave bus bundle for the factorial queue core
// rev 1.0
// ------------------------------------------------------------------
interface facto_queue_core_if #(
  parameter int DATA_W = 64
);
  logic              s_sel;
  logic              s_wr;
  logic [15:0]       s_addr;
  logic [DATA_W-1:0] s_din;
  logic [DATA_W-1:0] s_dout;

  modport master (
    output s_sel, s_wr, s_addr, s_din,
    input  s_dout
  );

  modport slave (
    input  s_sel, s_wr, s_addr, s_din,
    output s_dout
  );
endinterface
`default_nettype wire

// File: rtl/facto_queue_core.sv
`default_nettype none
`timescale 1ns/1ps
// ------------------------------------------------------------------
// facto_queue_core: FIFO-fed iterative shift-add factorial engine
// rev 1.0
// ------------------------------------------------------------------
module facto_queue_core #(
  parameter logic [15:0] BASE_ADDR = 16'h7000,
  parameter int          DATA_W    = 64,
  parameter int          OP_W      = 8,
  parameter int          DEPTH     = 4
) (
  input  wire logic          clk,
  input  wire logic          reset,
  facto_queue_core_if.slave  bus,
  output logic               interrupt
);

  localparam int RES_W  = 2 * DATA_W;
  localparam int PROD_W = RES_W + OP_W;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int MC_W   = $clog2(OP_W) + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MUL   = 3'd2,
    DEC   = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t            state;
  logic              run, mode, intren, push_err, ovf;
  logic [RES_W-1:0]  acc;
  logic [OP_W-1:0]   n, mplier;
  logic [PROD_W-1:0] partial, mcand;
  logic [MC_W-1:0]   mcnt;

  logic [OP_W-1:0]   op_mem  [DEPTH];
  logic [RES_W:0]    res_mem [DEPTH];
  logic [CW-1:0]     op_wptr, op_rptr, res_wptr, res_rptr;

  logic [CW-1:0]     op_count, res_count;
  logic              op_full, op_empty, res_full, res_empty;
  logic [OP_W-1:0]   op_head;
  logic [RES_W:0]    res_head;
  logic [OP_W-1:0]   n_dec;

  assign op_count  = op_wptr - op_rptr;
  assign res_count = res_wptr - res_rptr;
  assign op_full   = (op_count == CW'(DEPTH));
  assign op_empty  = (op_count == '0);
  assign res_full  = (res_count == CW'(DEPTH));
  assign res_empty = (res_count == '0);
  assign op_head   = op_mem[op_rptr[AW-1:0]];
  assign res_head  = res_empty ? '0 : res_mem[res_rptr[AW-1:0]];
  assign n_dec     = n - 1'b1;

  // Address decode: 8-byte stride window of eight registers above BASE_ADDR.
  logic [15:0] offset;
  logic        in_win;
  logic [2:0]  reg_idx;
  logic        wr_en, rd_en;
  logic        wr_start, wr_clear, wr_intren, wr_operand, wr_pop;
  logic        host_push, host_pop;

  assign offset     = bus.s_addr - BASE_ADDR;
  assign in_win     = (offset[15:6] == 10'd0) && (offset[2:0] == 3'd0);
  assign reg_idx    = offset[5:3];
  assign wr_en      = bus.s_sel & bus.s_wr & in_win;
  assign rd_en      = bus.s_sel & ~bus.s_wr & in_win;
  assign wr_start   = wr_en && (reg_idx == 3'd0);
  assign wr_clear   = wr_en && (reg_idx == 3'd1) && bus.s_din[0];
  assign wr_intren  = wr_en && (reg_idx == 3'd3);
  assign wr_operand = wr_en && (reg_idx == 3'd4);
  assign wr_pop     = wr_en && (reg_idx == 3'd7) && bus.s_din[0];
  assign host_push  = wr_operand & ~op_full;
  assign host_pop   = wr_pop & ~res_empty;

  logic [DATA_W-1:0] status, rd_data;

  always_comb begin
    status        = '0;
    status[0]     = ~res_empty;
    status[1]     = (state != IDLE);
    status[2]     = op_full;
    status[3]     = op_empty;
    status[4]     = res_head[RES_W];
    status[5]     = push_err;
    status[15:8]  = 8'(op_count);
    status[23:16] = 8'(res_count);
  end

  always_comb begin
    rd_data = '0;
    case (reg_idx)
      3'd2:    rd_data = status;
      3'd3:    rd_data = {{(DATA_W-1){1'b0}}, intren};
      3'd5:    rd_data = res_head[RES_W-1:DATA_W];
      3'd6:    rd_data = res_head[DATA_W-1:0];
      default: rd_data = '0;
    endcase
  end

  assign bus.s_dout = rd_en ? rd_data : '0;
  assign interrupt  = intren & ~res_empty;

  logic unused_din;
  assign unused_din = ^bus.s_din[DATA_W-1:OP_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      run      <= 1'b0;
      mode     <= 1'b0;
      intren   <= 1'b0;
      push_err <= 1'b0;
      ovf      <= 1'b0;
      acc      <= RES_W'(1);
      n        <= '0;
      mplier   <= '0;
      partial  <= '0;
      mcand    <= '0;
      mcnt     <= '0;
      op_wptr  <= '0;
      op_rptr  <= '0;
      res_wptr <= '0;
      res_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_mem[i]  <= '0;
        res_mem[i] <= '0;
      end
    end else if (wr_clear) begin
      // Abort dominates any same-cycle LOAD pop or WRITE push.
      state    <= IDLE;
      run      <= 1'b0;
      push_err <= 1'b0;
      ovf      <= 1'b0;
      op_wptr  <= '0;
      op_rptr  <= '0;
      res_wptr <= '0;
      res_rptr <= '0;
    end else begin
      if (wr_intren)
        intren <= bus.s_din[0];
      if (wr_operand) begin
        if (op_full) begin
          push_err <= 1'b1;
        end else begin
          op_mem[op_wptr[AW-1:0]] <= bus.s_din[OP_W-1:0];
          op_wptr                 <= op_wptr + 1'b1;
        end
      end
      if (host_pop)
        res_rptr <= res_rptr + 1'b1;

      case (state)
        IDLE: begin
          if (run && !op_empty && !res_full)
            state <= LOAD;
        end
        LOAD: begin
          n       <= op_head;
          mplier  <= op_head;
          acc     <= RES_W'(1);
          ovf     <= 1'b0;
          partial <= '0;
          mcand   <= PROD_W'(1);
          mcnt    <= '0;
          op_rptr <= op_rptr + 1'b1;
          state   <= (op_head <= OP_W'(1)) ? WRITE : MUL;
        end
        MUL: begin
          if (mplier[0])
            partial <= partial + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          mcnt   <= mcnt + 1'b1;
          if (mcnt == MC_W'(OP_W - 1))
            state <= DEC;
        end
        DEC: begin
          acc     <= partial[RES_W-1:0];
          ovf     <= ovf | (|partial[PROD_W-1:RES_W]);
          n       <= n_dec;
          mplier  <= n_dec;
          partial <= '0;
          mcand   <= {{OP_W{1'b0}}, partial[RES_W-1:0]};
          mcnt    <= '0;
          state   <= (n_dec <= OP_W'(1)) ? WRITE : MUL;
        end
        WRITE: begin
          res_mem[res_wptr[AW-1:0]] <= {ovf, acc};
          res_wptr <= res_wptr + 1'b1;
          state    <= IDLE;
          if (!mode || (op_empty && !host_push))
            run <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // A START write only touches run/mode, even mid-job.
      if (wr_start) begin
        if (bus.s_din[0])
          run <= 1'b1;
        mode <= bus.s_din[1];
      end
    end
  end

endmodule
`default_nettype wire
